// File: rtl/ctrl_decode_pipe.sv
`timescale 1ns/1ps
// RV32 main control decoder with ID/EX, EX/MEM and MEM/WB control registers.
// Includes load-use stall detection, a branch flush of the ID slot and illegal-opcode flagging.
module ctrl_decode_pipe #(
    parameter int ALUOP_W    = 2,
    parameter int REG_AW     = 5,
    parameter bit EN_IMM_ALU = 1'b1,
    parameter bit EN_JUMP    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [31:0]        id_inst,
    input  logic               flush,
    output logic               id_stall,
    output logic               id_illegal,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [REG_AW-1:0]  ex_rs1,
    output logic [REG_AW-1:0]  ex_rs2,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               mem_memrd,
    output logic               mem_memwr,
    output logic [REG_AW-1:0]  mem_rd,
    output logic               mem_regwr,
    output logic               wb_regwr,
    output logic               wb_mem2reg,
    output logic [REG_AW-1:0]  wb_rd
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               jump;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic               memrd;
        logic               memwr;
        logic               regwr;
        logic               mem2reg;
    } idex_t;

    typedef struct packed {
        logic              memrd;
        logic              memwr;
        logic              regwr;
        logic              mem2reg;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic              regwr;
        logic              mem2reg;
        logic [REG_AW-1:0] rd;
    } memwb_t;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] f_rs1;
    logic [REG_AW-1:0] f_rs2;
    logic [REG_AW-1:0] f_rd;
    logic              dec_illegal;
    logic              use_rs1;
    logic              use_rs2;
    logic              writes_reg;
    logic [1:0]        dec_aluop;
    idex_t             dec_b;
    logic              ex_hit;
    logic              load_bubble;
    logic              unused_inst_bits;

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;

    assign opcode           = id_inst[6:0];
    assign f_rs1            = REG_AW'(id_inst[19:15]);
    assign f_rs2            = REG_AW'(id_inst[24:20]);
    assign f_rd             = REG_AW'(id_inst[11:7]);
    assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:12]};

    // Opcode decode; disabled or unknown opcodes leave the bundle all-zero.
    always_comb begin
        dec_b       = '0;
        dec_illegal = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        writes_reg  = 1'b0;
        dec_aluop   = 2'b00;
        case (opcode)
            OP_R: begin
                writes_reg = 1'b1;
                dec_aluop  = 2'b10;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_LOAD: begin
                dec_b.alusrc  = 1'b1;
                dec_b.mem2reg = 1'b1;
                dec_b.memrd   = 1'b1;
                writes_reg    = 1'b1;
                use_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec_b.alusrc = 1'b1;
                dec_b.memwr  = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec_b.branch = 1'b1;
                dec_aluop    = 2'b01;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_IMM: begin
                if (EN_IMM_ALU) begin
                    dec_b.alusrc = 1'b1;
                    writes_reg   = 1'b1;
                    dec_aluop    = 2'b11;
                    use_rs1      = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                if (EN_IMM_ALU) begin
                    dec_b.alusrc = 1'b1;
                    writes_reg   = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_JAL: begin
                if (EN_JUMP) begin
                    dec_b.jump = 1'b1;
                    writes_reg = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (EN_JUMP) begin
                    dec_b.alusrc = 1'b1;
                    dec_b.jump   = 1'b1;
                    writes_reg   = 1'b1;
                    use_rs1      = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        dec_b.aluop = ALUOP_W'(dec_aluop);
        dec_b.rs1   = use_rs1 ? f_rs1 : '0;
        dec_b.rs2   = use_rs2 ? f_rs2 : '0;
        dec_b.rd    = writes_reg ? f_rd : '0;
        // x0 is hard-wired zero: never request a write to it.
        dec_b.regwr = writes_reg && (dec_b.rd != '0);
    end

    // Unused source fields are already zeroed, and ex rd of zero never matches.
    always_comb begin
        ex_hit = 1'b0;
        if (idex_q.memrd && (idex_q.rd != '0)) begin
            ex_hit = (use_rs1 && (f_rs1 == idex_q.rd)) ||
                     (use_rs2 && (f_rs2 == idex_q.rd));
        end
    end

    assign id_stall    = id_valid && !dec_illegal && ex_hit;
    assign id_illegal  = id_valid && dec_illegal;
    assign load_bubble = flush || id_stall || !id_valid;

    always_comb begin
        idex_d = load_bubble ? '0 : dec_b;
    end

    always_comb begin
        exmem_d.memrd   = idex_q.memrd;
        exmem_d.memwr   = idex_q.memwr;
        exmem_d.regwr   = idex_q.regwr;
        exmem_d.mem2reg = idex_q.mem2reg;
        exmem_d.rd      = idex_q.rd;
    end

    always_comb begin
        memwb_d.regwr   = exmem_q.regwr;
        memwb_d.mem2reg = exmem_q.mem2reg;
        memwb_d.rd      = exmem_q.rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alusrc  = idex_q.alusrc;
    assign ex_aluop   = idex_q.aluop;
    assign ex_branch  = idex_q.branch;
    assign ex_jump    = idex_q.jump;
    assign ex_rs1     = idex_q.rs1;
    assign ex_rs2     = idex_q.rs2;
    assign ex_rd      = idex_q.rd;
    assign mem_memrd  = exmem_q.memrd;
    assign mem_memwr  = exmem_q.memwr;
    assign mem_rd     = exmem_q.rd;
    assign mem_regwr  = exmem_q.regwr;
    assign wb_regwr   = memwb_q.regwr;
    assign wb_mem2reg = memwb_q.mem2reg;
    assign wb_rd      = memwb_q.rd;

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Parametrised successor to the single-stage registered main control decoder of the 5-stage RV32 pipeline.
- Decodes the ID-stage instruction and registers the control bundle into ID/EX. It then carries the stage-specific fields through EX/MEM and MEM/WB.
- Adds OP-IMM, jump and LUI decode, illegal-opcode flagging, x0 write suppression, load-use hazard stall and branch flush.
- Undefined opcodes produce a zeroed bundle with an illegal flag; outputs are never driven to z or x.

Parameters:
ALUOP_W, 2, width of aluop bus; must be >= 2; decode values are zero-extended.
REG_AW, 5, register address width.
EN_IMM_ALU, 1, decode OP-IMM (0010011) and LUI (0110111); when 0, both opcodes are illegal.
EN_JUMP, 1, decode JAL (1101111) and JALR (1100111); when 0, both opcodes are illegal.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  id_inst holds a real instruction
id_inst  input  32  instruction in ID
flush  input  1  branch/jump taken in EX; kill the ID instruction
id_stall  output  1  load-use hazard; upstream holds PC and IF/ID (combinational)
id_illegal  output  1  ID opcode undefined (combinational, qualified by id_valid)
ex_alusrc  output  1  ALU operand B = immediate
ex_aluop  output  ALUOP_W  ALU control class
ex_branch  output  1  conditional branch
ex_jump  output  1  unconditional jump
ex_rs1  output  REG_AW  source register 1 of the EX instruction
ex_rs2  output  REG_AW  source register 2 of the EX instruction
ex_rd  output  REG_AW  destination register of the EX instruction
mem_memrd  output  1  data memory read
mem_memwr  output  1  data memory write
mem_rd  output  REG_AW  destination register of the MEM instruction
mem_regwr  output  1  register write pending in MEM (for forwarding)
wb_regwr  output  1  register file write enable
wb_mem2reg  output  1  write-back source = memory
wb_rd  output  REG_AW  write-back register

Behaviour:
- Reset: while rst_n=0, every registered output is 0 and all stages hold a bubble. Reset is asynchronous and may assert mid-operation; all in-flight instructions are discarded.
- Latency: an instruction decoded in cycle N drives its ex_* outputs in N+1, mem_* in N+2 and wb_* in N+3.

Decode (alusrc, mem2reg, regwr, memrd, memwr, branch, jump, aluop):
- R 0110011: 0,0,1,0,0,0,0,10
- LOAD 0000011: 1,1,1,1,0,0,0,00
- STORE 0100011: 1,0,0,0,1,0,0,00
- BRANCH 1100011: 0,0,0,0,0,1,0,01
- OP-IMM: 1,0,1,0,0,0,0,11
- LUI: 1,0,1,0,0,0,0,00
- JAL: 0,0,1,0,0,0,1,00
- JALR: 1,0,1,0,0,0,1,00
- Any other opcode, including those disabled by parameter: all 0, id_illegal=1.
- Don't-care entries are fixed to 0.

Decode qualifiers:
- rs1 is used by all decoded types except LUI and JAL.
- rs2 is used only by R, STORE and BRANCH.
- Register fields are taken from inst[19:15], inst[24:20] and inst[11:7].
- When a source or destination field is unused, its ex_* field is 0.
- regwr is forced to 0 when rd=0, so writes to x0 are suppressed.

Hazard:
- id_stall=1 when all of the following hold: id_valid, the EX stage holds a load (internal EX-stage memrd), ex_rd!=0, and ex_rd equals a used rs1/rs2 of the ID instruction.
- An illegal instruction never stalls.

ID/EX load (priority order):
1. rst_n low.
2. flush: bubble.
3. id_stall: bubble; the ID instruction is re-presented next cycle.
4. id_valid=0: bubble.
5. Otherwise: the decoded bundle is loaded.

Later stages:
- EX/MEM and MEM/WB advance every cycle unconditionally.
- flush and stall never affect them.

Simultaneous events:
- flush and a stall condition in the same cycle: the flush wins, and id_stall is still reported.
- A bubble behaves as an all-zero bundle.

Test Plan:
- Reset sequencing: hold rst_n=0 with id_inst=0x00208033 (add x0? no: add x0,x1,x2 → use 0x002081B3 add x3,x1,x2), then release. Required: all outputs 0 during reset; the cycle after release, ex_aluop=10, ex_rd=3, ex_rs1=1, ex_rs2=2; wb_regwr=1 and wb_rd=3 two cycles later.
- Load-use stall: lw x5,0(x1) (0x0000A283) followed by add x6,x5,x7 (0x00728333). Required: id_stall=1 for exactly 1 cycle, then a bubble in EX (all ex_* 0), then the add enters EX with ex_rs1=5. Repeating with add x6,x0,x7 gives no stall.
- Flush on stall: assert flush together with the lw/add hazard. Required: ID/EX gets a bubble; the lw continues and shows mem_memrd=1 the next cycle.
- Illegal and disabled opcodes: inst=0x0000007F → id_illegal=1 and an all-zero bundle. With EN_JUMP=0, inst=0x008000EF (JAL) → id_illegal=1 and ex_jump=0.
- x0 write suppression and store: addi x0,x0,1 (0x00100013) → wb_regwr=0. sw x2,4(x1) (0x0020A223) → mem_memwr=1, ex_alusrc=1, wb_regwr=0.
- Back-to-back pipeline fill and drain: stream R, LOAD, STORE, BRANCH, OP-IMM, JALR on consecutive cycles with ALUOP_W=4. Required: each stage shows the decode table values at N+1/N+2/N+3, and aluop is zero-extended (e.g. 0011 for OP-IMM).
